// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one 32->128-bit word stacker between the key stream
// and the data stream. Each grant lasts exactly one block of N_WORDS words,
// and src_o tags the block so the core can route the stacked word.
// Optional build macro: STACK_ARB_KEY_PRIO_EN (strict key priority instead
// of round-robin arbitration).
module stack_arbiter #(
    parameter int unsigned N_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        enable_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [31:0] key_word_i,
    input  logic        dat_valid_i,
    output logic        dat_ready_o,
    input  logic [31:0] dat_word_i,
    output logic        stk_valid_o,
    input  logic        stk_ready_i,
    output logic [31:0] stk_word_o,
    output logic        stk_clr_o,
    output logic        stk_enable_o,
    output logic        src_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_KEY = 2'd1,
        GNT_DAT = 2'd2
    } state_e;

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_reg, last_next;   // 1 = key was granted last
    logic             src_reg, src_next;     // 1 = key, 0 = data

    // Forwarding is suppressed while disabled or while a clear is pending,
    // so no source word is consumed by a handshake that will not be counted.
    logic fwd_en;
    logic handshake;

    assign fwd_en       = enable_i & ~clr_i;
    assign handshake    = stk_valid_o & stk_ready_i;
    assign stk_clr_o    = clr_i | ~rst_ni;
    assign stk_enable_o = enable_i;
    assign src_o        = src_reg;
    assign busy_o       = (state_reg != IDLE);

    // Combinational forwarding of the granted stream to the stacker.
    always_comb begin
        stk_valid_o = 1'b0;
        stk_word_o  = 32'd0;
        key_ready_o = 1'b0;
        dat_ready_o = 1'b0;
        case (state_reg)
            GNT_KEY: begin
                stk_word_o  = key_word_i;
                stk_valid_o = fwd_en & key_valid_i;
                key_ready_o = fwd_en & stk_ready_i;
            end
            GNT_DAT: begin
                stk_word_o  = dat_word_i;
                stk_valid_o = fwd_en & dat_valid_i;
                dat_ready_o = fwd_en & stk_ready_i;
            end
            default: ;
        endcase
    end

    // Next-state: arbitration in IDLE, word counting inside a block.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        src_next   = src_reg;
        if (clr_i) begin
            state_next = IDLE;
            cnt_next   = '0;
            last_next  = 1'b0;
            src_next   = 1'b0;
        end else if (enable_i) begin
            case (state_reg)
                IDLE: begin
`ifdef STACK_ARB_KEY_PRIO_EN
                    if (key_valid_i) begin
`else
                    // On a tie the stream not granted last wins.
                    if (key_valid_i && (!dat_valid_i || !last_reg)) begin
`endif
                        state_next = GNT_KEY;
                        src_next   = 1'b1;
                    end else if (dat_valid_i) begin
                        state_next = GNT_DAT;
                        src_next   = 1'b0;
                    end
                end
                GNT_KEY, GNT_DAT: begin
                    if (handshake) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next   = '0;
                            state_next = IDLE;
                            last_next  = (state_reg == GNT_KEY);
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b0;
            src_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            src_reg   <= src_next;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter (N_WORDS = 4). Expected block order in the
// tie test follows STACK_ARB_KEY_PRIO_EN when that macro is defined.
module tb_stack_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        clr_i;
    logic        enable_i;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [31:0] key_word_i;
    logic        dat_valid_i;
    logic        dat_ready_o;
    logic [31:0] dat_word_i;
    logic        stk_valid_o;
    logic        stk_ready_i;
    logic [31:0] stk_word_o;
    logic        stk_clr_o;
    logic        stk_enable_o;
    logic        src_o;
    logic        busy_o;

    int checks;
    int failures;

    logic [31:0] kw [4];
    logic [31:0] dw [4];
    logic        exp_src [3];

    stack_arbiter #(.N_WORDS(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (clr_i),
        .enable_i     (enable_i),
        .key_valid_i  (key_valid_i),
        .key_ready_o  (key_ready_o),
        .key_word_i   (key_word_i),
        .dat_valid_i  (dat_valid_i),
        .dat_ready_o  (dat_ready_o),
        .dat_word_i   (dat_word_i),
        .stk_valid_o  (stk_valid_o),
        .stk_ready_i  (stk_ready_i),
        .stk_word_o   (stk_word_o),
        .stk_clr_o    (stk_clr_o),
        .stk_enable_o (stk_enable_o),
        .src_o        (src_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One line per stacker handshake.
    always @(posedge clk_i) begin
        if (rst_ni && stk_valid_o && stk_ready_i)
            $display("handshake src=%0d word=%h", src_o, stk_word_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        kw[0] = 32'h11111111; kw[1] = 32'h22222222; kw[2] = 32'h33333333; kw[3] = 32'h44444444;
        dw[0] = 32'hD0000001; dw[1] = 32'hD0000002; dw[2] = 32'hD0000003; dw[3] = 32'hD0000004;
`ifdef STACK_ARB_KEY_PRIO_EN
        exp_src[0] = 1'b1; exp_src[1] = 1'b1; exp_src[2] = 1'b1;
`else
        exp_src[0] = 1'b1; exp_src[1] = 1'b0; exp_src[2] = 1'b1;
`endif

        // ---- reset, then key only ----
        rst_ni = 1'b0; clr_i = 1'b0; enable_i = 1'b1;
        key_valid_i = 1'b0; key_word_i = 32'd0;
        dat_valid_i = 1'b0; dat_word_i = 32'd0; stk_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_key_ready", key_ready_o, 0);
        chk("rst_dat_ready", dat_ready_o, 0);
        chk("rst_stk_valid", stk_valid_o, 0);
        chk("rst_stk_word", stk_word_o, 0);
        chk("rst_src", src_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_stk_clr", stk_clr_o, 1);
        chk("rst_stk_enable", stk_enable_o, 1);

        rst_ni = 1'b1;
        key_valid_i = 1'b1; key_word_i = kw[0]; stk_ready_i = 1'b1;
        #1;
        chk("ko_idle_valid", stk_valid_o, 0);
        chk("ko_idle_ready", key_ready_o, 0);
        chk("ko_idle_clr", stk_clr_o, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            key_word_i = kw[i];
            #1;
            chk("ko_src", src_o, 1);
            chk("ko_busy", busy_o, 1);
            chk("ko_valid", stk_valid_o, 1);
            chk("ko_key_ready", key_ready_o, 1);
            chk("ko_dat_ready", dat_ready_o, 0);
            chk("ko_word", stk_word_o, kw[i]);
            tick();
        end
        key_valid_i = 1'b0;
        #1;
        chk("ko_end_busy", busy_o, 0);
        chk("ko_end_src", src_o, 1);
        chk("ko_end_valid", stk_valid_o, 0);

        // ---- tie: both streams valid, three blocks ----
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        key_valid_i = 1'b1; key_word_i = 32'hAAAAAAAA;
        dat_valid_i = 1'b1; dat_word_i = 32'hDDDDDDDD;
        stk_ready_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("tie_idle_busy", busy_o, 0);
            chk("tie_idle_valid", stk_valid_o, 0);
            tick();
            for (int w = 0; w < 4; w++) begin
                #1;
                chk("tie_src", src_o, exp_src[b]);
                chk("tie_word", stk_word_o, exp_src[b] ? 32'hAAAAAAAA : 32'hDDDDDDDD);
                chk("tie_key_ready", key_ready_o, exp_src[b]);
                chk("tie_dat_ready", dat_ready_o, !exp_src[b]);
                chk("tie_busy", busy_o, 1);
                tick();
            end
        end

        // ---- clear mid key block while data is valid ----
        dat_valid_i = 1'b0;
        #1;
        chk("clr_idle_busy", busy_o, 0);
        tick();
        dat_valid_i = 1'b1;
        #1;
        chk("clr_gnt_src", src_o, 1);
        chk("clr_gnt_ready", key_ready_o, 1);
        tick();
        tick();
        clr_i = 1'b1;
        #1;
        chk("clr_stk_clr", stk_clr_o, 1);
        chk("clr_busy_before", busy_o, 1);
        tick();
        clr_i = 1'b0;
        #1;
        chk("clr_busy_after", busy_o, 0);
        chk("clr_src_after", src_o, 0);
        chk("clr_stk_clr_off", stk_clr_o, 0);
        chk("clr_valid_after", stk_valid_o, 0);
        tick();
        #1;
        chk("clr_regrant_src", src_o, 1);
        chk("clr_regrant_key", key_ready_o, 1);
        chk("clr_regrant_dat", dat_ready_o, 0);
        for (int w = 0; w < 4; w++) tick();

        // ---- data block with backpressure and a valid gap ----
        key_valid_i = 1'b0; dat_valid_i = 1'b1; dat_word_i = dw[0]; stk_ready_i = 1'b0;
        #1;
        chk("bp_idle_busy", busy_o, 0);
        tick();
        key_valid_i = 1'b1;
        #1;
        chk("bp_src", src_o, 0);
        chk("bp_stall_valid", stk_valid_o, 1);
        chk("bp_stall_ready", dat_ready_o, 0);
        chk("bp_key_ready0", key_ready_o, 0);
        tick();
        stk_ready_i = 1'b1;
        #1;
        chk("bp_w1_word", stk_word_o, dw[0]);
        chk("bp_w1_ready", dat_ready_o, 1);
        tick();
        dat_word_i = dw[1]; stk_ready_i = 1'b0;
        #1;
        chk("bp_w2_stall", dat_ready_o, 0);
        tick();
        stk_ready_i = 1'b1;
        #1;
        chk("bp_w2_word", stk_word_o, dw[1]);
        tick();
        dat_valid_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #1;
            chk("bp_gap_valid", stk_valid_o, 0);
            chk("bp_gap_busy", busy_o, 1);
            chk("bp_gap_key_ready", key_ready_o, 0);
            chk("bp_gap_src", src_o, 0);
            tick();
        end
        dat_valid_i = 1'b1; dat_word_i = dw[2];
        #1;
        chk("bp_w3_word", stk_word_o, dw[2]);
        chk("bp_w3_valid", stk_valid_o, 1);
        tick();
        dat_word_i = dw[3];
        #1;
        chk("bp_w4_word", stk_word_o, dw[3]);
        chk("bp_w4_busy", busy_o, 1);
        tick();
        dat_valid_i = 1'b0; key_valid_i = 1'b0;
        #1;
        chk("bp_end_busy", busy_o, 0);
        chk("bp_end_src", src_o, 0);

        // ---- enable low mid key block ----
        key_valid_i = 1'b1; key_word_i = kw[0];
        tick();
        #1;
        chk("en_w1_ready", key_ready_o, 1);
        tick();
        enable_i = 1'b0;
        for (int e = 0; e < 5; e++) begin
            #1;
            chk("en_off_valid", stk_valid_o, 0);
            chk("en_off_ready", key_ready_o, 0);
            chk("en_off_enable", stk_enable_o, 0);
            chk("en_off_busy", busy_o, 1);
            chk("en_off_src", src_o, 1);
            tick();
        end
        enable_i = 1'b1;
        for (int w = 1; w < 4; w++) begin
            key_word_i = kw[w];
            #1;
            chk("en_on_valid", stk_valid_o, 1);
            chk("en_on_word", stk_word_o, kw[w]);
            chk("en_on_busy", busy_o, 1);
            tick();
        end
        key_valid_i = 1'b0;
        #1;
        chk("en_end_busy", busy_o, 0);
        chk("en_end_src", src_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
